// File: rtl/mem_quad_banked.sv
// Two read / two write memory over BANKS interleaved dual-port banks; bank conflicts go through
// per-pair write buffers with read forwarding. Define MEM_QUAD_BANKED_STATS_EN for conflict/stall counters.

module mem_dual #(
    parameter int          WIDTH = 8,
    parameter int          DEPTH = 32,
    parameter int unsigned INIT  = 0
) (
    input  logic                     clk,
    input  logic [$clog2(DEPTH)-1:0] i_addr_a,
    input  logic                     i_re_a,
    input  logic                     i_we_a,
    input  logic [WIDTH-1:0]         i_wdata_a,
    output logic [WIDTH-1:0]         o_rdata_a,
    input  logic [$clog2(DEPTH)-1:0] i_addr_b,
    input  logic                     i_re_b,
    input  logic                     i_we_b,
    input  logic [WIDTH-1:0]         i_wdata_b,
    output logic [WIDTH-1:0]         o_rdata_b
);
    // Words are stored XOR INIT so an array that powers up zeroed reads back as INIT.
    localparam logic [WIDTH-1:0] INIT_W = WIDTH'(INIT);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [WIDTH-1:0] r_rdata_a;
    logic [WIDTH-1:0] r_rdata_b;

    // Read-before-write; port b is written last so it wins on a same-address collision.
    always_ff @(posedge clk) begin
        if (i_re_a) r_rdata_a <= r_mem[i_addr_a] ^ INIT_W;
        if (i_re_b) r_rdata_b <= r_mem[i_addr_b] ^ INIT_W;
        if (i_we_a) r_mem[i_addr_a] <= i_wdata_a ^ INIT_W;
        if (i_we_b) r_mem[i_addr_b] <= i_wdata_b ^ INIT_W;
    end

    assign o_rdata_a = r_rdata_a;
    assign o_rdata_b = r_rdata_b;
endmodule

module mem_quad_banked #(
    parameter int          WIDTH      = 8,
    parameter int          DEPTH      = 64,
    parameter int          BANKS      = 2,
    parameter int unsigned INIT       = 0,
    parameter int          WBUF_DEPTH = 4,
    localparam int         AW         = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] data0,
    input  logic [WIDTH-1:0] data1,
    input  logic [AW-1:0]    wraddress0,
    input  logic [AW-1:0]    wraddress1,
    input  logic             wren0,
    input  logic             wren1,
    output logic             wr_ready0,
    output logic             wr_ready1,
    input  logic [AW-1:0]    rdaddress0,
    input  logic [AW-1:0]    rdaddress1,
    input  logic             rden0,
    input  logic             rden1,
    output logic [WIDTH-1:0] q0,
    output logic [WIDTH-1:0] q1,
    output logic             q_valid0,
    output logic             q_valid1
`ifdef MEM_QUAD_BANKED_STATS_EN
    ,
    output logic [31:0]      conflict_cnt,
    output logic [31:0]      stall_cnt
`endif
);
    localparam int BB  = $clog2(BANKS);
    localparam int BAW = AW - BB;
    localparam int PW  = $clog2(WBUF_DEPTH);
    localparam int CW  = PW + 1;

    logic [AW-1:0]    w_rd_addr [2];
    logic [AW-1:0]    w_wr_addr [2];
    logic             w_rden    [2];
    logic             w_wren    [2];
    logic [WIDTH-1:0] w_wdata   [2];

    assign w_rd_addr[0] = rdaddress0;
    assign w_rd_addr[1] = rdaddress1;
    assign w_wr_addr[0] = wraddress0;
    assign w_wr_addr[1] = wraddress1;
    assign w_rden[0]    = rden0;
    assign w_rden[1]    = rden1;
    assign w_wren[0]    = wren0;
    assign w_wren[1]    = wren1;
    assign w_wdata[0]   = data0;
    assign w_wdata[1]   = data1;

    logic [AW-1:0]    r_buf_addr [2][WBUF_DEPTH];
    logic [WIDTH-1:0] r_buf_data [2][WBUF_DEPTH];
    logic [PW-1:0]    r_head     [2];
    logic [PW-1:0]    r_tail     [2];
    logic [CW-1:0]    r_count    [2];

    logic             r_q_valid  [2];
    logic             r_fwd_hit  [2];
    logic [WIDTH-1:0] r_fwd_data [2];
    logic [BB-1:0]    r_rd_bank  [2];

    logic             w_ready     [2];
    logic             w_empty     [2];
    logic             w_accept    [2];
    logic             w_conflict  [2];
    logic             w_direct    [2];
    logic             w_enq       [2];
    logic             w_drain     [2];
    logic [BB-1:0]    w_rd_bank   [2];
    logic [BB-1:0]    w_wr_bank   [2];
    logic [BB-1:0]    w_head_bank [2];
    logic [AW-1:0]    w_head_addr [2];
    logic [WIDTH-1:0] w_head_data [2];

    // Nothing is accepted or drained while rst is high, so a reset drops buffered writes cleanly.
    always_comb begin
        for (int p = 0; p < 2; p++) begin
            w_rd_bank[p]   = w_rd_addr[p][BB-1:0];
            w_wr_bank[p]   = w_wr_addr[p][BB-1:0];
            w_head_addr[p] = r_buf_addr[p][r_head[p]];
            w_head_data[p] = r_buf_data[p][r_head[p]];
            w_head_bank[p] = w_head_addr[p][BB-1:0];
            w_ready[p]     = (r_count[p] != CW'(WBUF_DEPTH));
            w_empty[p]     = (r_count[p] == '0);
            w_accept[p]    = w_wren[p] && w_ready[p] && !rst;
            w_conflict[p]  = w_rden[p] && (w_rd_bank[p] == w_wr_bank[p]);
            w_direct[p]    = w_accept[p] && w_empty[p] && !w_conflict[p];
            w_enq[p]       = w_accept[p] && !w_direct[p];
            w_drain[p]     = !w_empty[p] && !rst
                             && !(w_rden[p] && (w_rd_bank[p] == w_head_bank[p]));
        end
    end

    logic             w_fwd_hit  [2];
    logic [WIDTH-1:0] w_fwd_data [2];

    // Scan oldest to youngest, buffer 0 before buffer 1: the last hit wins.
    always_comb begin : p_fwd
        logic [PW-1:0] v_idx;
        v_idx = '0;
        for (int p = 0; p < 2; p++) begin
            w_fwd_hit[p]  = 1'b0;
            w_fwd_data[p] = '0;
            for (int b = 0; b < 2; b++) begin
                for (int k = 0; k < WBUF_DEPTH; k++) begin
                    v_idx = r_head[b] + PW'(k);
                    if ((CW'(k) < r_count[b]) && (r_buf_addr[b][v_idx] == w_rd_addr[p])) begin
                        w_fwd_hit[p]  = 1'b1;
                        w_fwd_data[p] = r_buf_data[b][v_idx];
                    end
                end
            end
        end
    end

    logic [BAW-1:0]   w_bank_addr  [BANKS][2];
    logic             w_bank_re    [BANKS][2];
    logic             w_bank_we    [BANKS][2];
    logic [WIDTH-1:0] w_bank_wdata [BANKS][2];
    logic [WIDTH-1:0] w_bank_rdata [BANKS][2];

    always_comb begin
        for (int b = 0; b < BANKS; b++) begin
            for (int p = 0; p < 2; p++) begin
                w_bank_re[b][p]    = 1'b0;
                w_bank_we[b][p]    = 1'b0;
                w_bank_addr[b][p]  = w_rd_addr[p][AW-1:BB];
                w_bank_wdata[b][p] = w_wdata[p];
                if (w_rden[p] && (w_rd_bank[p] == BB'(b))) begin
                    w_bank_re[b][p] = 1'b1;
                end else if (w_drain[p] && (w_head_bank[p] == BB'(b))) begin
                    w_bank_we[b][p]    = 1'b1;
                    w_bank_addr[b][p]  = w_head_addr[p][AW-1:BB];
                    w_bank_wdata[b][p] = w_head_data[p];
                end else if (w_direct[p] && (w_wr_bank[p] == BB'(b))) begin
                    w_bank_we[b][p]   = 1'b1;
                    w_bank_addr[b][p] = w_wr_addr[p][AW-1:BB];
                end
            end
        end
    end

    for (genvar g = 0; g < BANKS; g++) begin : g_bank
        mem_dual #(
            .WIDTH (WIDTH),
            .DEPTH (DEPTH / BANKS),
            .INIT  (INIT)
        ) u_mem (
            .clk       (clk),
            .i_addr_a  (w_bank_addr[g][0]),
            .i_re_a    (w_bank_re[g][0]),
            .i_we_a    (w_bank_we[g][0]),
            .i_wdata_a (w_bank_wdata[g][0]),
            .o_rdata_a (w_bank_rdata[g][0]),
            .i_addr_b  (w_bank_addr[g][1]),
            .i_re_b    (w_bank_re[g][1]),
            .i_we_b    (w_bank_we[g][1]),
            .i_wdata_b (w_bank_wdata[g][1]),
            .o_rdata_b (w_bank_rdata[g][1])
        );
    end

    always_ff @(posedge clk) begin
        for (int p = 0; p < 2; p++) begin
            if (w_enq[p]) begin
                r_buf_addr[p][r_tail[p]] <= w_wr_addr[p];
                r_buf_data[p][r_tail[p]] <= w_wdata[p];
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int p = 0; p < 2; p++) begin
            if (rst) begin
                r_head[p]     <= '0;
                r_tail[p]     <= '0;
                r_count[p]    <= '0;
                r_q_valid[p]  <= 1'b0;
                r_fwd_hit[p]  <= 1'b0;
                r_fwd_data[p] <= '0;
                r_rd_bank[p]  <= '0;
            end else begin
                if (w_enq[p])   r_tail[p] <= r_tail[p] + PW'(1);
                if (w_drain[p]) r_head[p] <= r_head[p] + PW'(1);
                r_count[p]    <= r_count[p] + CW'(w_enq[p]) - CW'(w_drain[p]);
                r_q_valid[p]  <= w_rden[p];
                r_fwd_hit[p]  <= w_fwd_hit[p];
                r_fwd_data[p] <= w_fwd_data[p];
                r_rd_bank[p]  <= w_rd_bank[p];
            end
        end
    end

    assign wr_ready0 = w_ready[0];
    assign wr_ready1 = w_ready[1];
    assign q_valid0  = r_q_valid[0];
    assign q_valid1  = r_q_valid[1];
    assign q0 = r_q_valid[0] ? (r_fwd_hit[0] ? r_fwd_data[0] : w_bank_rdata[r_rd_bank[0]][0]) : '0;
    assign q1 = r_q_valid[1] ? (r_fwd_hit[1] ? r_fwd_data[1] : w_bank_rdata[r_rd_bank[1]][1]) : '0;

`ifdef MEM_QUAD_BANKED_STATS_EN
    logic [31:0] r_conflict_cnt;
    logic [31:0] r_stall_cnt;
    logic        w_conflict_ev;
    logic        w_stall_ev;

    assign w_conflict_ev = (w_enq[0] && w_conflict[0]) || (w_enq[1] && w_conflict[1]);
    assign w_stall_ev    = (w_wren[0] && !w_ready[0]) || (w_wren[1] && !w_ready[1]);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_conflict_cnt <= '0;
            r_stall_cnt    <= '0;
        end else begin
            if (w_conflict_ev && (r_conflict_cnt != '1)) r_conflict_cnt <= r_conflict_cnt + 32'd1;
            if (w_stall_ev && (r_stall_cnt != '1))       r_stall_cnt    <= r_stall_cnt + 32'd1;
        end
    end

    assign conflict_cnt = r_conflict_cnt;
    assign stall_cnt    = r_stall_cnt;
`endif
endmodule
